// File: rtl/step_clock_pkg.sv
// Shared definitions for the step-clock controller and the board displays.
// Contents: mode encodings, FSM state encoding, hex-to-segment glyph table.
package step_clock_pkg;

  // Mode input encodings
  localparam logic [1:0] MODE_SINGLE = 2'b00;
  localparam logic [1:0] MODE_FREE   = 2'b01;
  localparam logic [1:0] MODE_BURST  = 2'b10;
  localparam logic [1:0] MODE_LOCK   = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FREE  = 2'd1,
    ST_BURST = 2'd2
  } state_t;

  // Active-low seven-segment glyphs, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] HEX_GLYPH [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

endpackage

// File: rtl/step_clock_controller_key_debouncer.sv
// Push-button input path: 2-FF synchroniser, debouncer and press detect.
// Ports: clk, rst (sync, active-high), key (raw, active-low),
//        press (one-cycle pulse on each debounced 1->0 transition).
module key_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic key,
  output logic press
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic             sync1;
  logic             sync2;
  logic             level;
  logic             armed;
  logic [CNT_W-1:0] cnt;

  // Debounce only after a released sample has been seen since reset, so a
  // key held through reset needs a release and a fresh press.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      level <= 1'b1;
      armed <= 1'b0;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync1 <= key;
      sync2 <= sync1;
      press <= 1'b0;
      if (!armed) begin
        cnt   <= '0;
        armed <= sync2;
      end else if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(DEBOUNCE_CYCLES)) begin
        level <= sync2;
        cnt   <= '0;
        press <= ~sync2;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/step_clock_controller.sv
// Step-clock generator: single-step, free-run and burst step enables.
// Ports: Clock, Reset (sync, active-high), StepKey (raw, active-low),
//        Mode, Period, BurstLen, Halt in; StepEn (combinational pulse),
//        Busy, StepCount, HEX (active-low, digit i at [7i+6:7i]) out.
module step_clock_controller
  import step_clock_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned DIV_W           = 26,
  parameter int unsigned BURST_W         = 8,
  parameter int unsigned NDIGITS         = 4
) (
  input  logic                   Clock,
  input  logic                   Reset,
  input  logic                   StepKey,
  input  logic [1:0]             Mode,
  input  logic [DIV_W-1:0]       Period,
  input  logic [BURST_W-1:0]     BurstLen,
  input  logic                   Halt,
  output logic                   StepEn,
  output logic                   Busy,
  output logic [4*NDIGITS-1:0]   StepCount,
  output logic [7*NDIGITS-1:0]   HEX
);

  localparam int unsigned CNT_W = 4 * NDIGITS;

  logic               press;
  state_t             state;
  state_t             state_next;
  logic [DIV_W-1:0]   div_cnt;
  logic [DIV_W-1:0]   period_lat;
  logic [DIV_W-1:0]   period_eff;
  logic [BURST_W-1:0] remaining;
  logic               tick;
  logic               step;
  logic               load_rem;
  logic               dec_rem;

  key_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_key (
    .clk  (Clock),
    .rst  (Reset),
    .key  (StepKey),
    .press(press)
  );

  assign period_eff = (Period == '0) ? DIV_W'(1) : Period;
  assign tick       = (state != ST_IDLE) && (div_cnt == period_lat - DIV_W'(1));
  assign StepEn     = step;

  // Next-state and step decision; Halt overrides everything
  always_comb begin
    state_next = state;
    step       = 1'b0;
    load_rem   = 1'b0;
    dec_rem    = 1'b0;
    if (Halt) begin
      state_next = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (press) begin
            case (Mode)
              MODE_SINGLE: step = 1'b1;
              MODE_FREE:   state_next = ST_FREE;
              MODE_BURST: begin
                if (BurstLen != '0) begin
                  state_next = ST_BURST;
                  load_rem   = 1'b1;
                end
              end
              default: ;
            endcase
          end
        end
        ST_FREE: begin
          step = tick;
          if (press || (Mode != MODE_FREE)) state_next = ST_IDLE;
        end
        ST_BURST: begin
          step = tick;
          if (tick) begin
            dec_rem = 1'b1;
            if (remaining == BURST_W'(1)) state_next = ST_IDLE;
          end
          if (press) state_next = ST_IDLE;
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  // State, divider, burst and step counters; the period is latched at each
  // divider restart so a new Period applies from the next restart.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state      <= ST_IDLE;
      div_cnt    <= '0;
      period_lat <= '0;
      remaining  <= '0;
      Busy       <= 1'b0;
      StepCount  <= '0;
    end else begin
      state <= state_next;
      Busy  <= (state_next != ST_IDLE);
      if ((state == ST_IDLE) || (state_next != state) || tick) begin
        div_cnt    <= '0;
        period_lat <= period_eff;
      end else begin
        div_cnt <= div_cnt + DIV_W'(1);
      end
      if (load_rem) begin
        remaining <= BurstLen;
      end else if (dec_rem) begin
        remaining <= remaining - BURST_W'(1);
      end
      if (step) StepCount <= StepCount + CNT_W'(1);
    end
  end

  // Registered glyph decode, one per digit
  for (genvar g = 0; g < int'(NDIGITS); g++) begin : g_digit
    logic [6:0] seg;
    always_ff @(posedge Clock) begin
      if (Reset) seg <= HEX_GLYPH[0];
      else       seg <= HEX_GLYPH[StepCount[4*g +: 4]];
    end
    assign HEX[7*g +: 7] = seg;
  end

endmodule
